sqrt_iter_p: RTL and testbench

//  Parametrised integer square-root unit; next generation of the fixed 32-bit sqrt.

---
 rtl/sqrt_iter_p.sv | 148 ++++++++++++++
 tb/tb_sqrt_iter_p.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter_p.sv
// Iterative integer square root: floor(sqrt(initial_nr)), remainder and inexact/invalid flags.
// Optional round-to-nearest result with saturation when SQRT_ROUND_EN is defined.
module sqrt_iter_p #(
    parameter int WIDTH  = 32,
    parameter int STEPS  = 1,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     initial_nr,
    output logic                 busy,
    output logic                 ready,
    output logic [WIDTH/2-1:0]   result,
    output logic [WIDTH/2:0]     remainder,
    output logic                 Cflag,
    output logic                 Oflag,
    output logic [1:0]           state_dbg
);
    localparam int H  = WIDTH / 2;
    localparam int N  = H / STEPS;
    localparam int RW = H + 2;
    localparam int CW = $clog2(N + 1);

    // Handshake: start is a level sampled only in IDLE; ready is high for the whole
    // DONE state and falls on the first edge that sees start low.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       rad_q, rad_d;
    logic signed [RW-1:0]   rem_q, rem_d;
    logic [H-1:0]           root_q, root_d;
    logic [H-1:0]           result_q, result_d;
    logic [H:0]             remainder_q, remainder_d;
    logic                   cflag_q, cflag_d;
    logic                   oflag_q, oflag_d;

    logic signed [RW-1:0]   r, fix;
    logic [H-1:0]           q;
    logic [WIDTH-1:0]       d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        cflag_d     = cflag_q;
        oflag_d     = oflag_q;

        // Non-restoring recurrence; modulo-RW arithmetic is exact since every
        // partial remainder fits RW signed bits.
        r = rem_q;
        q = root_q;
        d = rad_q;
        for (int s = 0; s < STEPS; s++) begin
            if (!r[RW-1])
                r = ((r <<< 2) | RW'(d[WIDTH-1 -: 2])) - {q, 2'b01};
            else
                r = ((r <<< 2) | RW'(d[WIDTH-1 -: 2])) + {q, 2'b11};
            q = {q[H-2:0], ~r[RW-1]};
            d = d << 2;
        end
        fix = r[RW-1] ? (r + {1'b0, q, 1'b1}) : r;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((SIGNED != 0) && initial_nr[WIDTH-1]) begin
                        state_d     = DONE;
                        result_d    = '0;
                        remainder_d = '0;
                        cflag_d     = 1'b0;
                        oflag_d     = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = '0;
                        rad_d   = initial_nr;
                        rem_d   = '0;
                        root_d  = '0;
                    end
                end
            end
            CALC: begin
                rad_d  = d;
                rem_d  = r;
                root_d = q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d     = DONE;
                    remainder_d = (H + 1)'(fix);
                    cflag_d     = (fix != '0);
                    result_d    = q;
                    oflag_d     = 1'b0;
`ifdef SQRT_ROUND_EN
                    if ($unsigned(fix) > RW'(q)) begin
                        if (q == '1) begin
                            result_d = '1;
                            oflag_d  = 1'b1;
                        end else begin
                            result_d = q + 1'b1;
                        end
                    end
`endif
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            cflag_q     <= 1'b0;
            oflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            cflag_q     <= cflag_d;
            oflag_q     <= oflag_d;
        end
    end

    assign busy      = (state_q == CALC);
    assign ready     = (state_q == DONE);
    assign result    = result_q;
    assign remainder = remainder_q;
    assign Cflag     = cflag_q;
    assign Oflag     = oflag_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_sqrt_iter_p.sv
// Bench for sqrt_iter_p: three configurations checked against an arithmetic sqrt model.
module tb_sqrt_iter_p;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  st_in;
    logic [31:0] nr0, nr1;
    logic [15:0] nr2;

    logic        busy0, ready0, c0, o0, busy1, ready1, c1, o1, busy2, ready2, c2, o2;
    logic [15:0] res0, res1;
    logic [16:0] rem0, rem1;
    logic [7:0]  res2;
    logic [8:0]  rem2;
    logic [1:0]  sd0, sd1, sd2;

    sqrt_iter_p #(.WIDTH(32), .STEPS(1), .SIGNED(1)) u0 (
        .clk(clk), .rst(rst), .start(st_in[0]), .initial_nr(nr0), .busy(busy0), .ready(ready0),
        .result(res0), .remainder(rem0), .Cflag(c0), .Oflag(o0), .state_dbg(sd0));
    sqrt_iter_p #(.WIDTH(32), .STEPS(2), .SIGNED(0)) u1 (
        .clk(clk), .rst(rst), .start(st_in[1]), .initial_nr(nr1), .busy(busy1), .ready(ready1),
        .result(res1), .remainder(rem1), .Cflag(c1), .Oflag(o1), .state_dbg(sd1));
    sqrt_iter_p #(.WIDTH(16), .STEPS(2), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .start(st_in[2]), .initial_nr(nr2), .busy(busy2), .ready(ready2),
        .result(res2), .remainder(rem2), .Cflag(c2), .Oflag(o2), .state_dbg(sd2));

    int sel;
    logic        m_busy, m_ready, m_c, m_o;
    logic [15:0] m_res;
    logic [16:0] m_rem;
    logic [1:0]  m_st;

    always_comb begin
        m_busy = busy0; m_ready = ready0; m_c = c0; m_o = o0;
        m_res = res0; m_rem = rem0; m_st = sd0;
        case (sel)
            1: begin
                m_busy = busy1; m_ready = ready1; m_c = c1; m_o = o1;
                m_res = res1; m_rem = rem1; m_st = sd1;
            end
            2: begin
                m_busy = busy2; m_ready = ready2; m_c = c2; m_o = o2;
                m_res = {8'd0, res2}; m_rem = {8'd0, rem2}; m_st = sd2;
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] last_res;

    function automatic int dut_w(input int s);
        return (s == 2) ? 16 : 32;
    endfunction
    function automatic int dut_steps(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned r, t;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    task automatic model(input logic [31:0] x, output logic [15:0] er, output logic [16:0] erem,
                         output logic ec, output logic eo, output int elat);
        int w, h;
        longint unsigned xv, root, rem;
        w = dut_w(sel);
        h = w / 2;
        xv = (w == 16) ? longint'(x[15:0]) : longint'(x);
        if (sel == 0 && x[31]) begin
            er = 0; erem = 0; ec = 0; eo = 1; elat = 1;
        end else begin
            root = isqrt(xv);
            rem  = xv - root * root;
            er   = 16'(root);
            erem = 17'(rem);
            ec   = (rem != 0);
            eo   = 0;
`ifdef SQRT_ROUND_EN
            if (rem > root) begin
                if (root + 1 == (64'd1 << h)) begin
                    er = 16'((64'd1 << h) - 1);
                    eo = 1;
                end else begin
                    er = 16'(root + 1);
                end
            end
`endif
            elat = w / (2 * dut_steps(sel)) + 1;
        end
    endtask

    task automatic set_in(input logic s, input logic [31:0] x);
        st_in[sel] = s;
        case (sel)
            0: nr0 = x;
            1: nr1 = x;
            default: nr2 = x[15:0];
        endcase
    endtask

    // Called at a negedge; returns at the negedge where ready is first seen, start still high.
    task automatic run_op(input logic [31:0] x, input string name);
        logic [15:0] er; logic [16:0] erem; logic ec, eo; int elat, lat;
        model(x, er, erem, ec, eo, elat);
        set_in(1'b1, x);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1 set_in(1'b1, $urandom);
            @(negedge clk);
            if (k == 1 && elat > 1) begin
                n_checks++;
                if (m_busy !== 1'b1) begin
                    n_fail++; $display("FAIL %s busy in calc: got %b expected 1", name, m_busy);
                end
            end
            if (m_ready) begin lat = k; break; end
        end
        n_checks++;
        if (lat != elat) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        n_checks++;
        if (m_res !== er) begin
            n_fail++; $display("FAIL %s result: got %0h expected %0h", name, m_res, er);
        end
        n_checks++;
        if (m_rem !== erem) begin
            n_fail++; $display("FAIL %s remainder: got %0h expected %0h", name, m_rem, erem);
        end
        n_checks++;
        if ({m_c, m_o} !== {ec, eo}) begin
            n_fail++; $display("FAIL %s flags C,O: got %b%b expected %b%b", name, m_c, m_o, ec, eo);
        end
        last_res = er;
    endtask

    task automatic drop_start(input string name);
        set_in(1'b0, $urandom);
        @(posedge clk);
        #1;
        n_checks++;
        if (m_ready !== 1'b0 || m_res !== last_res) begin
            n_fail++;
            $display("FAIL %s drop start: got ready=%b result=%0h expected ready=0 result=%0h",
                     name, m_ready, m_res, last_res);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        sel = 0;
        #1;
        n_checks++;
        if ({busy0, ready0, res0, rem0, c0, o0, sd0} !== '0) begin
            n_fail++; $display("FAIL reset outputs: got b%b r%b %0h %0h c%b o%b st%0d expected all 0",
                               busy0, ready0, res0, rem0, c0, o0, sd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_invalid();
        sel = 0;
        run_op(32'hFFFF_FFC0, "neg64");
        drop_start("neg64");
    endtask

    task automatic test_hold_start();
        sel = 0;
        run_op(32'd64, "sq64");
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (m_ready !== 1'b1 || m_busy !== 1'b0 || m_res !== 16'd8) begin
                n_fail++; $display("FAIL hold start: got ready=%b busy=%b result=%0h expected 1 0 8",
                                   m_ready, m_busy, m_res);
            end
        end
        drop_start("sq64");
    endtask

    task automatic test_vectors();
        logic [31:0] v [8];
        v = '{32'd72, 32'd73, 32'd0, 32'd1, 32'd2, 32'd3, 32'h7FFF_FFFF, 32'h4000_0000};
        sel = 0;
        foreach (v[i]) begin
            run_op(v[i], $sformatf("vec_%0h", v[i]));
            drop_start("vec");
        end
    endtask

    task automatic test_unsigned_max();
        sel = 1;
        run_op(32'hFFFF_FFFF, "u32max");
        drop_start("u32max");
        run_op(32'hFFFE_0001, "u32sq");
        drop_start("u32sq");
        sel = 2;
        run_op(32'h0000_FFFF, "u16max");
        drop_start("u16max");
    endtask

    task automatic test_reset_mid_calc();
        sel = 0;
        set_in(1'b1, 32'd1000);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({busy0, ready0, res0, rem0, c0, o0, sd0} !== '0) begin
            n_fail++; $display("FAIL reset mid calc: got b%b r%b %0h %0h c%b o%b st%0d expected all 0",
                               busy0, ready0, res0, rem0, c0, o0, sd0);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd1_000_000, "after_rst");
        drop_start("after_rst");
    endtask

    task automatic test_random();
        logic [31:0] x, root;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int i = 0; i < 15; i++) begin
                case ($urandom_range(0, 2))
                    0: x = $urandom;
                    1: x = $urandom_range(0, 300);
                    default: begin
                        root = $urandom_range(0, (s == 2) ? 255 : 65535);
                        x = root * root + $urandom_range(0, 1) * (2 * root);
                    end
                endcase
                if (s == 2) x = {16'd0, x[15:0]};
                run_op(x, $sformatf("rnd%0d_%0h", s, x));
                drop_start("rnd");
            end
        end
    endtask

    initial begin
        st_in = '0; nr0 = '0; nr1 = '0; nr2 = '0; sel = 0; last_res = '0;
        test_reset();
        test_invalid();
        test_hold_start();
        test_vectors();
        test_unsigned_max();
        test_reset_mid_calc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
